// File: rtl/octopos_reset_requester.sv
// AXI4-Lite master that writes a reset command to the Octopos reset module,
// then polls its status register until the reset completes, errors or times out.
module octopos_reset_requester #(
   parameter int                      ADDR_WIDTH  = 32,
   parameter int                      DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0]   CMD_ADDR    = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0]   STATUS_ADDR = 32'h0000_0004,
   parameter logic [DATA_WIDTH-1:0]   CMD_WORD    = 32'h0000_0001,
   parameter logic [DATA_WIDTH-1:0]   STATUS_MASK = 32'h0000_0001,
   parameter int                      POLL_GAP    = 16,
   parameter int                      TIMEOUT     = 4096
) (
   input  logic                      m00_axi_aclk,
   input  logic                      m00_axi_areset,
   input  logic                      req,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [1:0]                err_code,
   output logic [ADDR_WIDTH-1:0]     m00_axi_awaddr,
   output logic [2:0]                m00_axi_awprot,
   output logic                      m00_axi_awvalid,
   input  logic                      m00_axi_awready,
   output logic [DATA_WIDTH-1:0]     m00_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m00_axi_wstrb,
   output logic                      m00_axi_wvalid,
   input  logic                      m00_axi_wready,
   input  logic [1:0]                m00_axi_bresp,
   input  logic                      m00_axi_bvalid,
   output logic                      m00_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m00_axi_araddr,
   output logic [2:0]                m00_axi_arprot,
   output logic                      m00_axi_arvalid,
   input  logic                      m00_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m00_axi_rdata,
   input  logic [1:0]                m00_axi_rresp,
   input  logic                      m00_axi_rvalid,
   output logic                      m00_axi_rready
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(POLL_GAP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_GAP, S_DONE, S_ERR
   } state_t;

   state_t                    state_reg, state_next;
   logic                      aw_done_reg, aw_done_next;
   logic                      w_done_reg, w_done_next;
   logic                      tmo_pend_reg, tmo_pend_next;
   logic [TW-1:0]             tmo_cnt_reg, tmo_cnt_next;
   logic [GW-1:0]             gap_cnt_reg, gap_cnt_next;
   logic [1:0]                err_code_reg, err_code_next;
   logic [ADDR_WIDTH-1:0]     awaddr_reg, awaddr_next;
   logic [ADDR_WIDTH-1:0]     araddr_reg, araddr_next;
   logic [DATA_WIDTH-1:0]     wdata_reg, wdata_next;
   logic [DATA_WIDTH/8-1:0]   wstrb_reg, wstrb_next;

   logic                      aw_fin, w_fin, tmo_expire;
   logic [TW-1:0]             tmo_dec;
   logic [GW-1:0]             gap_dec;

   assign m00_axi_awvalid = (state_reg == S_WRITE) && !aw_done_reg;
   assign m00_axi_wvalid  = (state_reg == S_WRITE) && !w_done_reg;
   assign m00_axi_bready  = (state_reg == S_WRESP);
   assign m00_axi_arvalid = (state_reg == S_RADDR);
   assign m00_axi_rready  = (state_reg == S_RDATA);
   assign m00_axi_awprot  = 3'b000;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_awaddr  = awaddr_reg;
   assign m00_axi_araddr  = araddr_reg;
   assign m00_axi_wdata   = wdata_reg;
   assign m00_axi_wstrb   = wstrb_reg;
   assign busy            = (state_reg != S_IDLE);
   assign done            = (state_reg == S_DONE);
   assign error           = (state_reg == S_ERR);
   assign err_code        = err_code_reg;

   assign aw_fin     = aw_done_reg || (m00_axi_awvalid && m00_axi_awready);
   assign w_fin      = w_done_reg  || (m00_axi_wvalid  && m00_axi_wready);
   // Expiry means this cycle's decrement lands on zero; counters never wrap.
   assign tmo_expire = (tmo_cnt_reg <= TW'(1));
   assign tmo_dec    = (tmo_cnt_reg != '0) ? tmo_cnt_reg - TW'(1) : '0;
   assign gap_dec    = (gap_cnt_reg != '0) ? gap_cnt_reg - GW'(1) : '0;

   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) begin
         state_reg    <= S_IDLE;
         aw_done_reg  <= 1'b0;
         w_done_reg   <= 1'b0;
         tmo_pend_reg <= 1'b0;
         tmo_cnt_reg  <= '0;
         gap_cnt_reg  <= '0;
         err_code_reg <= 2'd0;
         awaddr_reg   <= '0;
         araddr_reg   <= '0;
         wdata_reg    <= '0;
         wstrb_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         aw_done_reg  <= aw_done_next;
         w_done_reg   <= w_done_next;
         tmo_pend_reg <= tmo_pend_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         err_code_reg <= err_code_next;
         awaddr_reg   <= awaddr_next;
         araddr_reg   <= araddr_next;
         wdata_reg    <= wdata_next;
         wstrb_reg    <= wstrb_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      aw_done_next  = aw_done_reg;
      w_done_next   = w_done_reg;
      tmo_pend_next = tmo_pend_reg;
      tmo_cnt_next  = tmo_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      err_code_next = err_code_reg;
      awaddr_next   = awaddr_reg;
      araddr_next   = araddr_reg;
      wdata_next    = wdata_reg;
      wstrb_next    = wstrb_reg;

      case (state_reg)
         S_IDLE: begin
            if (req) begin
               state_next    = S_WRITE;
               aw_done_next  = 1'b0;
               w_done_next   = 1'b0;
               tmo_pend_next = 1'b0;
               err_code_next = 2'd0;
               tmo_cnt_next  = TW'(TIMEOUT);
               awaddr_next   = CMD_ADDR;
               wdata_next    = CMD_WORD;
               wstrb_next    = '1;
               araddr_next   = STATUS_ADDR;
            end
         end
         S_WRITE: begin
            tmo_cnt_next = tmo_dec;
            aw_done_next = aw_fin;
            w_done_next  = w_fin;
            if (aw_fin && w_fin) begin
               state_next = S_WRESP;
            end else if (tmo_expire) begin
               state_next    = S_ERR;
               err_code_next = 2'd3;
            end
         end
         S_WRESP: begin
            tmo_cnt_next = tmo_dec;
            if (m00_axi_bvalid) begin
               if (m00_axi_bresp != 2'b00) begin
                  state_next    = S_ERR;
                  err_code_next = 2'd1;
               end else begin
                  state_next = S_RADDR;
               end
            end else if (tmo_expire) begin
               state_next    = S_ERR;
               err_code_next = 2'd3;
            end
         end
         S_RADDR: begin
            tmo_cnt_next = tmo_dec;
            if (m00_axi_arready) begin
               state_next = S_RDATA;
            end else if (tmo_expire) begin
               state_next    = S_ERR;
               err_code_next = 2'd3;
            end
         end
         S_RDATA: begin
            tmo_cnt_next = tmo_dec;
            // A read already issued is always drained so no R beat is orphaned.
            if (m00_axi_rvalid) begin
               if (tmo_pend_reg) begin
                  state_next    = S_ERR;
                  err_code_next = 2'd3;
               end else if (m00_axi_rresp != 2'b00) begin
                  state_next    = S_ERR;
                  err_code_next = 2'd2;
               end else if ((m00_axi_rdata & STATUS_MASK) == '0) begin
                  state_next = S_DONE;
               end else begin
                  state_next   = S_GAP;
                  gap_cnt_next = GW'(POLL_GAP);
               end
            end else if (tmo_expire) begin
               tmo_pend_next = 1'b1;
            end
         end
         S_GAP: begin
            tmo_cnt_next = tmo_dec;
            gap_cnt_next = gap_dec;
            if (tmo_expire) begin
               state_next    = S_ERR;
               err_code_next = 2'd3;
            end else if (gap_cnt_reg <= GW'(1)) begin
               state_next = S_RADDR;
            end
         end
         S_DONE:  state_next = S_IDLE;
         S_ERR:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_octopos_reset_requester.sv
// Bench for octopos_reset_requester: configurable AXI-Lite slave, a per-cycle
// behavioural model of the requester's visible rules, and directed transactions.
module tb_octopos_reset_requester;

   localparam int TMO = 64;
   localparam int GAP = 16;

   logic        clk = 1'b0;
   logic        areset;
   logic        req;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   octopos_reset_requester #(.POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
      .m00_axi_aclk(clk), .m00_axi_areset(areset), .req(req),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
      .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
      .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
      .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
      .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
      .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
      .m00_axi_rready(rready)
   );

   // ---------------- slave configuration (written by the stimulus only)
   int         aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
   logic [1:0] bresp_cfg = 2'b00;
   int         n_busy = 0, r_base = 0;

   // ---------------- slave state
   int   aw_wait, w_wait, b_wait, r_wait, r_total_s;
   logic aw_got, w_got, b_pend, r_pend;

   assign awready = awvalid && (aw_wait >= aw_delay);
   assign wready  = wvalid && (w_wait >= w_delay);
   assign arready = arvalid;
   assign bresp   = bvalid ? bresp_cfg : 2'b00;
   assign rresp   = 2'b00;
   // Status reads 1 for the first n_busy reads of a transaction, then 0.
   assign rdata   = ((r_total_s - r_base) < n_busy) ? 32'h1 : 32'h0;

   always @(posedge clk or posedge areset) begin
      if (areset) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_wait <= 0; r_total_s <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         if (bvalid && bready) bvalid <= 1'b0;
         if (b_pend) begin
            if (b_wait <= 1) begin bvalid <= 1'b1; b_pend <= 1'b0; end
            else b_wait <= b_wait - 1;
         end
         if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            if (b_delay == 0) bvalid <= 1'b1;
            else begin b_pend <= 1'b1; b_wait <= b_delay; end
         end else begin
            aw_got <= aw_got || (awvalid && awready);
            w_got  <= w_got || (wvalid && wready);
         end
         if (rvalid && rready) begin rvalid <= 1'b0; r_total_s <= r_total_s + 1; end
         if (r_pend) begin
            if (r_wait <= 1) begin rvalid <= 1'b1; r_pend <= 1'b0; end
            else r_wait <= r_wait - 1;
         end
         if (arvalid && arready) begin
            if (r_delay == 0) rvalid <= 1'b1;
            else begin r_pend <= 1'b1; r_wait <= r_delay; end
         end
      end
   end

   // ---------------- checking state
   int checks = 0, errors = 0, cyc = 0;
   logic       m_busy = 1'b0, pulse_prev = 1'b0;
   logic [1:0] m_code = 2'd0, scen_code = 2'd0;
   logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rr, p_rv;
   int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, done_n = 0, err_n = 0;
   int awv_last = -1, wv_last = -1;
   int ar_hs_q[$], ar_rise_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One cycle: advance to the negedge, compare the DUT with the model, log handshakes.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (areset) begin
         m_busy = 1'b0; m_code = 2'd0; pulse_prev = 1'b0;
         {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rr, p_rv} = '0;
      end else begin
         if (m_busy && pulse_prev) m_busy = 1'b0;
         else if (!m_busy && req) begin m_busy = 1'b1; m_code = 2'd0; end
         if (done) m_code = 2'd0;
         if (error) m_code = scen_code;
         chk("busy", busy, m_busy);
         chk("err_code", err_code, m_code);
         chk("pulse_excl", done && error, 1'b0);
         if (!busy) chk("idle_quiet", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
         if (awvalid) chk("aw_payload", {awprot, awaddr}, {3'b000, 32'h0});
         if (wvalid) chk("w_payload", {wstrb, wdata}, {4'hF, 32'h1});
         if (arvalid) chk("ar_payload", {arprot, araddr}, {3'b000, 32'h4});
         if (p_awv && !p_awr) chk("aw_hold", awvalid || error, 1'b1);
         if (p_wv && !p_wr) chk("w_hold", wvalid || error, 1'b1);
         if (p_arv && !p_arr) chk("ar_hold", arvalid || error, 1'b1);
         if (p_rr && !p_rv) chk("r_hold", rready, 1'b1);
         if (awvalid && awready) aw_n++;
         if (wvalid && wready) w_n++;
         if (bvalid && bready) b_n++;
         if (rvalid && rready) r_n++;
         if (arvalid && arready) begin ar_n++; ar_hs_q.push_back(cyc); end
         if (arvalid && !p_arv) ar_rise_q.push_back(cyc);
         if (awvalid) awv_last = cyc;
         if (wvalid) wv_last = cyc;
         if (done) done_n++;
         if (error) err_n++;
         pulse_prev = done || error;
         {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rr, p_rv} =
            {awvalid, awready, wvalid, wready, arvalid, arready, rready, rvalid};
      end
   endtask

   task automatic run_txn(input string name, input int awd, input int bd, input int rd,
                          input logic [1:0] br, input int nbusy, input logic exp_ok,
                          input logic [1:0] exp_code, input int exp_ar,
                          output int c0, output int lat);
      int aw0, w0, b0, ar0, r0, d0, e0;
      bit got;
      aw_delay = awd; w_delay = 0; b_delay = bd; r_delay = rd; bresp_cfg = br;
      n_busy = nbusy; r_base = r_total_s; scen_code = exp_code;
      aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n; d0 = done_n; e0 = err_n;
      req = 1'b1; c0 = cyc;
      tick();
      req = 1'b0;
      got = 0; lat = -1;
      for (int i = 0; i < 300 && !got; i++) begin
         tick();
         if (done || error) begin got = 1; lat = cyc - c0; end
      end
      if (!got) chk({name, ".no_pulse"}, 1'b0, 1'b1);
      tick(); tick();
      chk({name, ".done_cnt"}, done_n - d0, exp_ok ? 1 : 0);
      chk({name, ".err_cnt"}, err_n - e0, exp_ok ? 0 : 1);
      chk({name, ".code"}, err_code, exp_code);
      chk({name, ".aw_cnt"}, aw_n - aw0, 1);
      chk({name, ".w_cnt"}, w_n - w0, 1);
      chk({name, ".b_cnt"}, b_n - b0, 1);
      if (exp_ar >= 0) chk({name, ".ar_cnt"}, ar_n - ar0, exp_ar);
      chk({name, ".r_eq_ar"}, r_n - r0, ar_n - ar0);
      chk({name, ".busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int c0, lat, q0;
      areset = 1'b1; req = 1'b0;
      repeat (3) tick();
      chk("rst_ctl", {busy, done, error, err_code}, 5'b0);
      chk("rst_valid", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
      chk("rst_addr", {awaddr, araddr}, 64'h0);
      chk("rst_data", {wstrb, wdata}, 36'h0);
      areset = 1'b0;
      repeat (2) tick();

      run_txn("zero_wait", 0, 0, 0, 2'b00, 0, 1'b1, 2'd0, 1, c0, lat);
      chk("zero_wait.latency", lat, 5);
      chk("zero_wait.awv_cycle", awv_last - c0, 1);
      chk("zero_wait.wv_cycle", wv_last - c0, 1);

      run_txn("aw_delay", 2, 0, 0, 2'b00, 0, 1'b1, 2'd0, 1, c0, lat);
      chk("aw_delay.wv_last", wv_last - c0, 1);
      chk("aw_delay.awv_last", awv_last - c0, 3);
      chk("aw_delay.latency", lat, 7);

      q0 = ar_hs_q.size();
      run_txn("poll", 0, 0, 0, 2'b00, 2, 1'b1, 2'd0, 3, c0, lat);
      for (int k = q0 + 1; k < ar_hs_q.size(); k++)
         chk("poll.gap_ok", (ar_rise_q[k] - ar_hs_q[k-1] - 1) >= GAP, 1'b1);

      run_txn("bresp_err", 0, 0, 0, 2'b10, 0, 1'b0, 2'd1, 0, c0, lat);
      chk("bresp_err.latency", lat, 3);

      run_txn("tmo_gap", 0, 0, 0, 2'b00, 1000, 1'b0, 2'd3, -1, c0, lat);
      chk("tmo_gap.not_early", lat >= TMO, 1'b1);
      chk("tmo_gap.bounded", lat <= TMO + 2, 1'b1);

      run_txn("tmo_rdata", 0, 0, 10, 2'b00, 1000, 1'b0, 2'd3, -1, c0, lat);
      chk("tmo_rdata.not_early", lat >= TMO, 1'b1);
      chk("tmo_rdata.bounded", lat <= TMO + 13, 1'b1);

      // Reset in WRESP: stall B so the requester is parked waiting for it.
      b_delay = 5; aw_delay = 0; r_delay = 0; bresp_cfg = 2'b00; scen_code = 2'd0;
      req = 1'b1;
      tick();
      req = 1'b0;
      for (int i = 0; i < 20 && !bready; i++) tick();
      chk("rst_mid.in_wresp", bready, 1'b1);
      areset = 1'b1;
      #1;
      chk("rst_mid.async", {busy, done, error, err_code, awvalid, wvalid, bready, arvalid, rready}, 14'b0);
      chk("rst_mid.async_addr", {awaddr, araddr, wdata}, 96'h0);
      tick();
      chk("rst_mid.edge", {busy, done, error, err_code, awvalid, wvalid, bready, arvalid, rready}, 14'b0);
      chk("rst_mid.edge_data", {wstrb, awaddr, araddr, wdata}, 100'h0);
      tick();
      areset = 1'b0;
      repeat (2) tick();
      run_txn("after_rst", 0, 0, 0, 2'b00, 0, 1'b1, 2'd0, 1, c0, lat);
      chk("after_rst.latency", lat, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
